// File: rtl/regfile_scanner_pkg.sv
// Shared definitions for the register-file scanner: FSM encoding and the
// legality check for the scanned address window.
package regfile_scanner_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_CAPT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // The window must be non-empty and must fit inside the address space.
  function automatic bit addr_range_ok(input int first_addr, input int last_addr,
                                       input int addr_w);
    return (first_addr >= 32'sd0) && (first_addr <= last_addr) &&
           (last_addr <= ((32'sd1 <<< addr_w) - 32'sd1));
  endfunction

endpackage

// File: rtl/regfile_scanner_if.sv
// Regfile read port plus the (addr, data) valid/ready output stream.
// The master modport is the scanner side.
interface regfile_scanner_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rd_en, rd_addr, out_valid, out_addr, out_data,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_addr, out_data,
    output rd_data, out_ready
  );

endinterface

// File: rtl/regfile_scanner_scan_addr_counter.sv
// Loadable scan-address counter. It stops at LAST_ADDR so the address never
// wraps, even when LAST_ADDR is the top of the address space.
module scan_addr_counter #(
  parameter int ADDR_W     = 5,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              i_load,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_is_last
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  logic [ADDR_W-1:0] r_count;
  logic              w_is_last;

  assign w_is_last = (r_count == LAST_A);

  // Address register: load has priority, increment is refused at the last address.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= {ADDR_W{1'b0}};
    end else if (i_load) begin
      r_count <= FIRST_A;
    end else if (i_inc && !w_is_last) begin
      r_count <= r_count + ONE_A;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count   = r_count;
  assign o_is_last = w_is_last;

endmodule

// File: rtl/regfile_scanner.sv
// Walks FIRST_ADDR..LAST_ADDR through the regfile read port and presents each
// captured word as (addr, data) on a valid/ready stream, then pulses done.
module regfile_scanner
  import regfile_scanner_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  regfile_scanner_if.master  bus
);

  if (!addr_range_ok(FIRST_ADDR, LAST_ADDR, ADDR_W)) begin : g_bad_range
    $error("regfile_scanner: FIRST_ADDR/LAST_ADDR outside legal window");
  end

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_is_last;
  logic              w_handshake;
  logic              w_load;
  logic              w_inc;

  assign w_handshake = r_out_valid & bus.out_ready;
  assign w_load      = (r_state == S_IDLE) & start & ~abort;
  assign w_inc       = (r_state == S_PRESENT) & w_handshake & ~abort & ~w_is_last;

  scan_addr_counter #(
    .ADDR_W     (ADDR_W),
    .FIRST_ADDR (FIRST_ADDR),
    .LAST_ADDR  (LAST_ADDR)
  ) u_addr (
    .clk       (clk),
    .clr_n     (clr_n),
    .i_load    (w_load),
    .i_inc     (w_inc),
    .o_count   (w_rd_addr),
    .o_is_last (w_is_last)
  );

  // Scan FSM; abort from any active state returns to IDLE and drops any in-flight read.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= {ADDR_W{1'b0}};
      r_out_data  <= {DATA_W{1'b0}};
    end else if (abort && (r_state != S_IDLE)) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start && !abort) begin
            r_state <= S_REQ;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_rd_en <= 1'b0;
          end
        end
        S_REQ: begin
          r_rd_en <= 1'b0;
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          r_out_data  <= bus.rd_data;
          r_out_addr  <= w_rd_addr;
          r_out_valid <= 1'b1;
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (w_is_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_rd_en <= 1'b1;
            end
          end else begin
            r_state <= S_PRESENT;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_rd_en     <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = w_rd_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;

endmodule
